// File: rtl/adsr_envelope_bank.sv
// Multi-voice ADSR envelope bank sharing one prescaled update tick.
// Optional macro ADSR_EXP_RELEASE_EN selects an exponential-like release tail.
package CONFIG;
  localparam int AUDIO_BIT_WIDTH = 16;
endpackage

module adsr_envelope_bank #(
  parameter int VOICES      = 8,
  parameter int LEVEL_WIDTH = CONFIG::AUDIO_BIT_WIDTH,
  parameter int TICK_DIVIDE = 1024
) (
  input  logic                                  clock_50_000_000,
  input  logic                                  reset_l,
  input  logic [LEVEL_WIDTH-1:0]                attack_step,
  input  logic [LEVEL_WIDTH-1:0]                decay_step,
  input  logic [LEVEL_WIDTH-1:0]                sustain_level,
  input  logic [LEVEL_WIDTH-1:0]                release_step,
  input  logic [VOICES-1:0]                     note_on,
  input  logic [VOICES-1:0]                     note_off,
  output logic [VOICES-1:0][LEVEL_WIDTH-1:0]    envelope,
  output logic [VOICES-1:0]                     active,
  output logic [VOICES-1:0]                     envelope_end
);

  localparam int CW = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;
  localparam logic [LEVEL_WIDTH-1:0] MAX_LEVEL = '1;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } state_t;

  logic [CW-1:0] r_tickCount;
  logic          w_tick;

  assign w_tick = (r_tickCount == CW'(TICK_DIVIDE - 1));

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      r_tickCount <= '0;
    end else if (w_tick) begin
      r_tickCount <= '0;
    end else begin
      r_tickCount <= r_tickCount + 1'b1;
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    state_t                 r_state;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic                   r_end;
    logic [LEVEL_WIDTH:0]   w_attackSum;
    logic [LEVEL_WIDTH:0]   w_releaseDec;
    logic                   w_decayDone;
    logic                   w_releaseDone;

    assign w_attackSum = {1'b0, r_level} + {1'b0, attack_step};
`ifdef ADSR_EXP_RELEASE_EN
    assign w_releaseDec = {1'b0, r_level >> 3} + {1'b0, release_step};
`else
    assign w_releaseDec = {1'b0, release_step};
`endif
    // Level lands on the sustain floor when the step would cross it (or it already sits below).
    assign w_decayDone   = (r_level <= sustain_level) ||
                           ((r_level - sustain_level) <= decay_step);
    assign w_releaseDone = (w_releaseDec >= {1'b0, r_level});

    // Triggers override the tick update; note_on keeps the level for a click-free retrigger.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) begin
        r_state <= IDLE;
        r_level <= '0;
        r_end   <= 1'b0;
      end else begin
        r_end <= 1'b0;
        if (note_on[v]) begin
          r_state <= ATTACK;
        end else if (note_off[v] && (r_state == ATTACK || r_state == DECAY ||
                                     r_state == SUSTAIN)) begin
          r_state <= RELEASE;
        end else if (w_tick) begin
          case (r_state)
            ATTACK: begin
              if (w_attackSum >= {1'b0, MAX_LEVEL}) begin
                r_level <= MAX_LEVEL;
                r_state <= DECAY;
              end else begin
                r_level <= w_attackSum[LEVEL_WIDTH-1:0];
              end
            end
            DECAY: begin
              if (w_decayDone) begin
                r_level <= sustain_level;
                r_state <= SUSTAIN;
              end else begin
                r_level <= r_level - decay_step;
              end
            end
            SUSTAIN: r_level <= sustain_level;
            RELEASE: begin
              if (w_releaseDone) begin
                r_level <= '0;
                r_state <= IDLE;
                r_end   <= 1'b1;
              end else begin
                r_level <= r_level - w_releaseDec[LEVEL_WIDTH-1:0];
              end
            end
            default: r_level <= '0;
          endcase
        end
      end
    end

    assign envelope[v]     = r_level;
    assign active[v]       = (r_state != IDLE);
    assign envelope_end[v] = r_end;
  end

endmodule

// File: tb/tb_adsr_envelope_bank.sv
// Bench for adsr_envelope_bank: directed ADSR scenarios plus random triggers,
// checked every cycle against a cycle-level arithmetic model of the envelope rules.
module tb_adsr_envelope_bank;

  localparam int LW   = 8;
  localparam int NV   = 2;
  localparam int TD   = 4;
  localparam int MAXL = 255;

  localparam int ST_IDLE    = 0;
  localparam int ST_ATTACK  = 1;
  localparam int ST_DECAY   = 2;
  localparam int ST_SUSTAIN = 3;
  localparam int ST_RELEASE = 4;

`ifdef ADSR_EXP_RELEASE_EN
  localparam int RETRIG_LEVEL = -1;
`else
  localparam int RETRIG_LEVEL = 64;
`endif

  logic                   clock_50_000_000 = 1'b0;
  logic                   reset_l = 1'b0;
  logic [LW-1:0]          attackStep = 8'd64;
  logic [LW-1:0]          decayStep = 8'd16;
  logic [LW-1:0]          sustainLevel = 8'd128;
  logic [LW-1:0]          releaseStep = 8'd32;
  logic [NV-1:0]          noteOn = '0;
  logic [NV-1:0]          noteOff = '0;
  logic [NV-1:0][LW-1:0]  envelope;
  logic [NV-1:0]          active;
  logic [NV-1:0]          envelopeEnd;

  int checks = 0;
  int failures = 0;
  int mLevel[NV];
  int mStage[NV];
  bit mEnd[NV];
  int mCount;
  int endSeen[NV];
  int peakSeen[NV];

  adsr_envelope_bank #(
    .VOICES(NV),
    .LEVEL_WIDTH(LW),
    .TICK_DIVIDE(TD)
  ) dut (
    .clock_50_000_000(clock_50_000_000),
    .reset_l(reset_l),
    .attack_step(attackStep),
    .decay_step(decayStep),
    .sustain_level(sustainLevel),
    .release_step(releaseStep),
    .note_on(noteOn),
    .note_off(noteOff),
    .envelope(envelope),
    .active(active),
    .envelope_end(envelopeEnd)
  );

  always #5 clock_50_000_000 = ~clock_50_000_000;

  task automatic modelReset();
    mCount = 0;
    for (int v = 0; v < NV; v++) begin
      mLevel[v] = 0;
      mStage[v] = ST_IDLE;
      mEnd[v]   = 1'b0;
    end
  endtask

  // One rising edge of the envelope rules, using plain integer min/max arithmetic.
  task automatic modelEdge(input logic [NV-1:0] on, input logic [NV-1:0] off);
    bit tick;
    int dec;
    tick   = (mCount == TD - 1);
    mCount = (mCount + 1) % TD;
    for (int v = 0; v < NV; v++) begin
      mEnd[v] = 1'b0;
      if (on[v]) begin
        mStage[v] = ST_ATTACK;
      end else if (off[v] && mStage[v] != ST_IDLE && mStage[v] != ST_RELEASE) begin
        mStage[v] = ST_RELEASE;
      end else if (tick) begin
        case (mStage[v])
          ST_ATTACK: begin
            mLevel[v] = mLevel[v] + int'(attackStep);
            if (mLevel[v] >= MAXL) begin
              mLevel[v] = MAXL;
              mStage[v] = ST_DECAY;
            end
          end
          ST_DECAY: begin
            mLevel[v] = mLevel[v] - int'(decayStep);
            if (mLevel[v] <= int'(sustainLevel)) begin
              mLevel[v] = int'(sustainLevel);
              mStage[v] = ST_SUSTAIN;
            end
          end
          ST_SUSTAIN: mLevel[v] = int'(sustainLevel);
          ST_RELEASE: begin
            dec = int'(releaseStep);
`ifdef ADSR_EXP_RELEASE_EN
            dec = dec + mLevel[v] / 8;
`endif
            mLevel[v] = (mLevel[v] > dec) ? mLevel[v] - dec : 0;
            if (mLevel[v] == 0) begin
              mStage[v] = ST_IDLE;
              mEnd[v]   = 1'b1;
            end
          end
          default: mLevel[v] = 0;
        endcase
      end
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    for (int v = 0; v < NV; v++) begin
      checks++;
      assert (envelope[v] === LW'(mLevel[v])) else begin
        failures++;
        $error("FAIL envelope[%0d] observed=%0d expected=%0d", v, envelope[v], mLevel[v]);
      end
      checks++;
      assert (active[v] === (mStage[v] != ST_IDLE)) else begin
        failures++;
        $error("FAIL active[%0d] observed=%b expected=%b", v, active[v], mStage[v] != ST_IDLE);
      end
      checks++;
      assert (envelopeEnd[v] === mEnd[v]) else begin
        failures++;
        $error("FAIL envelope_end[%0d] observed=%b expected=%b", v, envelopeEnd[v], mEnd[v]);
      end
      if (envelopeEnd[v] === 1'b1) endSeen[v]++;
      if (int'(envelope[v]) > peakSeen[v]) peakSeen[v] = int'(envelope[v]);
    end
  endtask

  // Inputs are driven just after an edge, so the next edge samples them cleanly.
  task automatic applyStimulus(input logic [NV-1:0] on, input logic [NV-1:0] off);
    noteOn  = on;
    noteOff = off;
    @(posedge clock_50_000_000);
    modelEdge(on, off);
    #1;
    noteOn  = '0;
    noteOff = '0;
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0);
  endtask

  task automatic runUntilModel(input int v, input int stage, input int level,
                               input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      applyStimulus('0, '0);
      found = (mStage[v] == stage) && (level < 0 || mLevel[v] == level);
    end
    checks++;
    assert (found) else begin
      failures++;
      $error("FAIL %s observed=timeout expected=reached within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    int endSnapshot;
    logic [NV-1:0] rOn;
    logic [NV-1:0] rOff;

    modelReset();
    for (int v = 0; v < NV; v++) begin
      endSeen[v]  = 0;
      peakSeen[v] = 0;
    end
    repeat (2) @(posedge clock_50_000_000);
    #1;
    checkOutput();
    reset_l = 1'b1;

    // Basic envelope on voice 0.
    applyStimulus(2'b01, 2'b00);
    checkValue("active_after_note_on", int'(active[0]), 1);
    runUntilModel(0, ST_SUSTAIN, 128, 100, "reach_sustain");
    checkValue("sustain_level", int'(envelope[0]), 128);
    checkValue("attack_peak", peakSeen[0], 255);
    runCycles(8);
    applyStimulus(2'b00, 2'b01);
    runUntilModel(0, ST_IDLE, 0, 60, "release_to_idle");
    runCycles(2);
    checkValue("basic_end_pulses", endSeen[0], 1);
    checkValue("basic_active_low", int'(active[0]), 0);
    checkValue("voice1_untouched", peakSeen[1], 0);

    // Retrigger during release.
    applyStimulus(2'b01, 2'b00);
    runUntilModel(0, ST_SUSTAIN, 128, 100, "retrig_sustain");
    applyStimulus(2'b00, 2'b01);
    runUntilModel(0, ST_RELEASE, RETRIG_LEVEL, 40, "retrig_release_level");
    endSnapshot = endSeen[0];
    applyStimulus(2'b01, 2'b00);
    runUntilModel(0, ST_ATTACK, -1, 8, "retrig_attack");
    checkValue("retrig_no_end_pulse", endSeen[0], endSnapshot);
    checkValue("retrig_active", int'(active[0]), 1);

    // Simultaneous note_on/note_off on idle voice 1.
    applyStimulus(2'b10, 2'b10);
    checkValue("simul_enters_attack", int'(active[1]), 1);
    runCycles(8);
    applyStimulus(2'b00, 2'b10);
    runUntilModel(1, ST_IDLE, 0, 80, "simul_release_idle");
    applyStimulus(2'b00, 2'b10);
    runCycles(4);
    checkValue("note_off_idle_ignored", int'(active[1]), 0);

    // Live sustain change and stalled attack.
    runUntilModel(0, ST_SUSTAIN, 128, 100, "live_sustain_entry");
    sustainLevel = 8'd200;
    runCycles(5);
    checkValue("live_sustain_200", int'(envelope[0]), 200);
    attackStep = 8'd0;
    applyStimulus(2'b01, 2'b00);
    runCycles(12);
    checkValue("attack_step0_hold", int'(envelope[0]), 200);
    checkValue("attack_step0_active", int'(active[0]), 1);
    attackStep   = 8'd64;
    sustainLevel = 8'd128;

    // Asynchronous reset while in DECAY.
    runUntilModel(0, ST_DECAY, 239, 40, "reach_decay");
    #1;
    reset_l = 1'b0;
    #1;
    checkValue("async_reset_envelope", int'(envelope), 0);
    checkValue("async_reset_active", int'(active), 0);
    checkValue("async_reset_end", int'(envelopeEnd), 0);
    modelReset();
    @(posedge clock_50_000_000);
    #1;
    checkOutput();
    reset_l = 1'b1;
    runCycles(6);
    checkValue("post_reset_idle", int'(active[0]), 0);

    // Randomised triggers and parameters.
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) begin
        attackStep   = LW'($urandom_range(0, 90));
        decayStep    = LW'($urandom_range(0, 40));
        sustainLevel = LW'($urandom_range(0, 255));
        releaseStep  = LW'($urandom_range(0, 60));
      end
      for (int v = 0; v < NV; v++) begin
        rOn[v]  = ($urandom_range(0, 24) == 0);
        rOff[v] = ($urandom_range(0, 12) == 0);
      end
      applyStimulus(rOn, rOff);
    end

    $display("[TB] directed and random phases complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
